// File: rtl/bp_me_pkg.sv
`default_nettype none
// ============================================================================
// bp_me_pkg: shared ME types (buffer stats record, credit-counter op encoding).
// Rev 1.0
// ============================================================================
package bp_me_pkg;

  localparam int unsigned c_stall_width = 32;

  typedef struct packed {
    logic [c_stall_width-1:0] stall_cycles;
    logic [c_stall_width-1:0] peak_outstanding;
  } bp_me_mem_buffer_stats_s;

  typedef enum logic [1:0] {
    e_credit_hold   = 2'd0,
    e_credit_take   = 2'd1,
    e_credit_return = 2'd2
  } bp_me_credit_op_e;

  function automatic logic [c_stall_width-1:0] sat_inc32(input logic [c_stall_width-1:0] v);
    return (&v) ? v : v + c_stall_width'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_me_mem_credit_counter.sv
`default_nettype none
// ============================================================================
// bp_me_mem_credit_counter: response-credit counter with optional stall/peak
// stats (BP_ME_MEM_BUFFER_STATS_EN). Rev 1.0
// ============================================================================
module bp_me_mem_credit_counter
  import bp_me_pkg::*;
#(
  parameter int max_p       = 4,
  parameter int cnt_width_p = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   inc_i,
  input  logic                   dec_i,
  input  logic                   pending_i,
  output logic [cnt_width_p-1:0] count_o,
  output logic                   avail_o,
  output logic [31:0]            stall_cycles_o,
  output logic [cnt_width_p-1:0] peak_o
);

  logic [cnt_width_p-1:0] count_q, count_d;
  logic                   credit_free;
  bp_me_credit_op_e       op;

  assign credit_free = (count_q < cnt_width_p'(max_p));
  // avail_o means "the waiting head command may issue now".
  assign avail_o     = pending_i & credit_free;
  assign count_o     = count_q;

  always_comb begin
    op = e_credit_hold;
    if (inc_i && !dec_i && credit_free) begin
      op = e_credit_take;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      op = e_credit_return;
    end
    count_d = count_q;
    case (op)
      e_credit_take:   count_d = count_q + cnt_width_p'(1);
      e_credit_return: count_d = count_q - cnt_width_p'(1);
      default:         count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef BP_ME_MEM_BUFFER_STATS_EN
  logic [31:0]            stall_q, stall_d;
  logic [cnt_width_p-1:0] peak_q, peak_d;

  // Peak follows the next count so it never lags the visible outstanding value.
  always_comb begin
    stall_d = (pending_i && !credit_free) ? sat_inc32(stall_q) : stall_q;
    peak_d  = (count_d > peak_q) ? count_d : peak_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stall_q <= '0;
      peak_q  <= '0;
    end else begin
      stall_q <= stall_d;
      peak_q  <= peak_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign peak_o         = peak_q;
`else
  assign stall_cycles_o = '0;
  assign peak_o         = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// bsg_fifo_1r1w_small: registered ring-buffer FIFO, valid-ready in, valid-yumi out.
// Rev 1.0
// ============================================================================
module bsg_fifo_1r1w_small
  import bp_me_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                enq, deq;

  // Full/empty come straight from the registered count, so ready never looks ahead.
  assign ready_o = (count_q != cnt_w_lp'(els_p));
  assign v_o     = (count_q != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_q[rptr_q];

  function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_comb begin
    rptr_d  = deq ? wrap_inc(rptr_q) : rptr_q;
    wptr_d  = enq ? wrap_inc(wptr_q) : wptr_q;
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bp_me_mem_credit_buffer.sv
`default_nettype none
// ============================================================================
// bp_me_mem_credit_buffer: command/response buffer that issues a command only
// once its response slot is reserved. Optional: BP_ME_MEM_BUFFER_STATS_EN. Rev 1.0
// ============================================================================
module bp_me_mem_credit_buffer
  import bp_me_pkg::*;
#(
  parameter  int width_p      = 64,
  parameter  int cmd_els_p    = 4,
  parameter  int resp_els_p   = 4,
  localparam int cnt_width_lp = $clog2(resp_els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,

  input  logic [width_p-1:0]      mem_cmd_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_o,

  output logic [width_p-1:0]      mem_resp_o,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_yumi_i,

  output logic [width_p-1:0]      mem_cmd_o,
  output logic                    mem_cmd_v_o,
  input  logic                    mem_cmd_ready_i,

  input  logic [width_p-1:0]      mem_resp_i,
  input  logic                    mem_resp_v_i,
  output logic                    mem_resp_ready_o,

  output logic [cnt_width_lp-1:0] outstanding_o,
  output logic                    idle_o,
  output logic                    error_o,
  output logic [31:0]             stall_cycles_o,
  output logic [cnt_width_lp-1:0] peak_outstanding_o
);

  logic                    cmd_fifo_ready, cmd_fifo_v;
  logic                    resp_fifo_ready, resp_fifo_v;
  logic                    issue, resp_enq, resp_deq, issue_ok;
  logic [cnt_width_lp-1:0] outstanding;
  logic [cnt_width_lp-1:0] resp_cnt_q, resp_cnt_d;
  logic                    error_q, error_d;

  // Reset masks every handshake immediately, before the FIFO state has cleared.
  assign mem_cmd_ready_o  = reset_n_i & cmd_fifo_ready;
  assign mem_resp_ready_o = reset_n_i & resp_fifo_ready;
  assign mem_cmd_v_o      = reset_n_i & issue_ok;
  assign mem_resp_v_o     = reset_n_i & resp_fifo_v;

  assign issue    = mem_cmd_v_o & mem_cmd_ready_i;
  assign resp_enq = mem_resp_v_i & mem_resp_ready_o;
  assign resp_deq = mem_resp_yumi_i & mem_resp_v_o;

  bsg_fifo_1r1w_small #(
    .width_p (width_p),
    .els_p   (cmd_els_p)
  ) cmd_fifo (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .v_i     (mem_cmd_v_i),
    .ready_o (cmd_fifo_ready),
    .data_i  (mem_cmd_i),
    .v_o     (cmd_fifo_v),
    .data_o  (mem_cmd_o),
    .yumi_i  (issue)
  );

  bsg_fifo_1r1w_small #(
    .width_p (width_p),
    .els_p   (resp_els_p)
  ) resp_fifo (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .v_i     (mem_resp_v_i),
    .ready_o (resp_fifo_ready),
    .data_i  (mem_resp_i),
    .v_o     (resp_fifo_v),
    .data_o  (mem_resp_o),
    .yumi_i  (resp_deq)
  );

  bp_me_mem_credit_counter #(
    .max_p       (resp_els_p),
    .cnt_width_p (cnt_width_lp)
  ) credit_counter (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .inc_i          (issue),
    .dec_i          (resp_deq),
    .pending_i      (cmd_fifo_v),
    .count_o        (outstanding),
    .avail_o        (issue_ok),
    .stall_cycles_o (stall_cycles_o),
    .peak_o         (peak_outstanding_o)
  );

  // A response is solicited only while memory still owes us one:
  // credits held beyond those already sitting in the response FIFO.
  always_comb begin
    resp_cnt_d = resp_cnt_q;
    case ({resp_enq, resp_deq})
      2'b10:   resp_cnt_d = resp_cnt_q + cnt_width_lp'(1);
      2'b01:   resp_cnt_d = resp_cnt_q - cnt_width_lp'(1);
      default: resp_cnt_d = resp_cnt_q;
    endcase
    error_d = error_q | (resp_enq & (resp_cnt_q >= outstanding));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      resp_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      resp_cnt_q <= resp_cnt_d;
      error_q    <= error_d;
    end
  end

  assign outstanding_o = outstanding;
  assign error_o       = error_q;
  assign idle_o        = ~reset_n_i | (~cmd_fifo_v & ~resp_fifo_v & (outstanding == '0));

endmodule
`default_nettype wire

// File: tb/tb_bp_me_mem_credit_buffer.sv
`default_nettype none
// ============================================================================
// tb_bp_me_mem_credit_buffer: vector table, directed corner sequences and
// random traffic against a queue-based reference model. Rev 1.0
// ============================================================================
module tb_bp_me_mem_credit_buffer;

  localparam int W  = 16;
  localparam int CE = 4;
  localparam int RE = 4;
  localparam logic [W-1:0] RK = 16'h5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic [W-1:0] cmd_i, resp_o, cmd_o, resp_i;
  logic         cmd_v_i, cmd_ready_o, resp_v_o, resp_yumi_i;
  logic         cmd_v_o, cmd_ready_i, resp_v_i, resp_ready_o;
  logic [2:0]   outstanding_o, peak_o;
  logic         idle_o, error_o;
  logic [31:0]  stall_o;

  bp_me_mem_credit_buffer #(
    .width_p    (W),
    .cmd_els_p  (CE),
    .resp_els_p (RE)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .mem_cmd_i          (cmd_i),
    .mem_cmd_v_i        (cmd_v_i),
    .mem_cmd_ready_o    (cmd_ready_o),
    .mem_resp_o         (resp_o),
    .mem_resp_v_o       (resp_v_o),
    .mem_resp_yumi_i    (resp_yumi_i),
    .mem_cmd_o          (cmd_o),
    .mem_cmd_v_o        (cmd_v_o),
    .mem_cmd_ready_i    (cmd_ready_i),
    .mem_resp_i         (resp_i),
    .mem_resp_v_i       (resp_v_i),
    .mem_resp_ready_o   (resp_ready_o),
    .outstanding_o      (outstanding_o),
    .idle_o             (idle_o),
    .error_o            (error_o),
    .stall_cycles_o     (stall_o),
    .peak_outstanding_o (peak_o)
  );

  // Reference model: commands waiting, responses waiting, commands held by memory.
  logic [W-1:0] m_cmd[$], m_rf[$], m_mem[$];
  int           m_out, m_peak;
  bit           m_err;
  logic [31:0]  m_stall;

  int n_tests = 0, n_fail = 0, n_issued = 0;

  logic         s_cmd_rdy, s_cmd_v, s_resp_rdy, s_resp_v, s_idle, s_err;
  logic [W-1:0] s_cmd, s_resp;
  logic [2:0]   s_out, s_peak;
  logic [31:0]  s_stall;

  typedef struct {
    bit rn, cv; logic [W-1:0] cd; bit cr, rv; logic [W-1:0] rd; bit y;
    bit e_cr, e_cv; logic [W-1:0] e_cmd; bit e_rr, e_rv; logic [W-1:0] e_resp;
    int e_out; bit e_idle, e_err;
  } vec_t;
  vec_t tbl[8];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic cycle(input bit rn, input bit cv, input logic [W-1:0] cd, input bit cr,
                       input bit rv, input logic [W-1:0] rd, input bit y);
    bit e_cr, e_cv, e_rr, e_rv, e_idle, y_eff, issue, renq;
    e_cr   = rn && (m_cmd.size() < CE);
    e_cv   = rn && (m_cmd.size() > 0) && (m_out < RE);
    e_rr   = rn && (m_rf.size() < RE);
    e_rv   = rn && (m_rf.size() > 0);
    e_idle = !rn || (m_cmd.size() == 0 && m_rf.size() == 0 && m_out == 0);
    y_eff  = y && e_rv;
    reset_n = rn; cmd_v_i = cv; cmd_i = cd; cmd_ready_i = cr;
    resp_v_i = rv; resp_i = rd; resp_yumi_i = y_eff;
    #4;
    s_cmd_rdy = cmd_ready_o; s_cmd_v = cmd_v_o; s_resp_rdy = resp_ready_o; s_resp_v = resp_v_o;
    s_idle = idle_o; s_err = error_o; s_cmd = cmd_o; s_resp = resp_o;
    s_out = outstanding_o; s_peak = peak_o; s_stall = stall_o;
    check("cmd_ready", s_cmd_rdy, e_cr);
    check("cmd_v", s_cmd_v, e_cv);
    check("resp_ready", s_resp_rdy, e_rr);
    check("resp_v", s_resp_v, e_rv);
    check("outstanding", s_out, m_out);
    check("idle", s_idle, e_idle);
    check("error", s_err, m_err);
    check("stall_cycles", s_stall, m_stall);
    check("peak", s_peak, m_peak);
    if (e_cv) check("cmd_data", s_cmd, m_cmd[0]);
    if (e_rv) check("resp_data", s_resp, m_rf[0]);
    if (!rn) begin
      m_cmd.delete(); m_rf.delete(); m_mem.delete();
      m_out = 0; m_err = 0; m_stall = 0; m_peak = 0;
    end else begin
      issue = e_cv && cr;
      renq  = rv && e_rr;
`ifdef BP_ME_MEM_BUFFER_STATS_EN
      if (m_cmd.size() > 0 && m_out >= RE && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
      if (renq) begin
        if (m_rf.size() >= m_out) m_err = 1;
        m_rf.push_back(rd);
        if (m_mem.size() > 0) void'(m_mem.pop_front());
      end
      if (y_eff) void'(m_rf.pop_front());
      if (issue) begin
        m_mem.push_back(m_cmd.pop_front());
        n_issued++;
      end
      if (cv && e_cr) m_cmd.push_back(cd);
      if (issue && !y_eff) m_out++;
      else if (!issue && y_eff && m_out > 0) m_out--;
`ifdef BP_ME_MEM_BUFFER_STATS_EN
      if (m_out > m_peak) m_peak = m_out;
`endif
    end
    @(posedge clk); #1;
  endtask

  // Memory stand-in: answers the oldest issued command with cmd ^ RK when enabled.
  task automatic tick(input bit rn, input bit cv, input logic [W-1:0] cd, input bit cr,
                      input bit en, input bit y);
    bit rv;
    logic [W-1:0] rd;
    rv = en && (m_mem.size() > 0);
    rd = rv ? (m_mem[0] ^ RK) : '0;
    cycle(rn, cv, cd, cr, rv, rd, y);
  endtask

  task automatic do_reset();
    tick(0, 0, '0, 0, 0, 0);
    tick(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    tbl[0] = '{0,0,16'h0,0,0,16'h0,0, 0,0,16'h0,   0,0,16'h0,   0,1,0};
    tbl[1] = '{1,1,16'h1234,1,0,16'h0,0, 1,0,16'h0, 1,0,16'h0,  0,1,0};
    tbl[2] = '{1,0,16'h0,1,0,16'h0,0, 1,1,16'h1234, 1,0,16'h0,  0,0,0};
    tbl[3] = '{1,0,16'h0,1,0,16'h0,0, 1,0,16'h0,   1,0,16'h0,   1,0,0};
    tbl[4] = '{1,0,16'h0,1,0,16'h0,0, 1,0,16'h0,   1,0,16'h0,   1,0,0};
    tbl[5] = '{1,0,16'h0,1,1,16'hBEEF,0, 1,0,16'h0, 1,0,16'h0,  1,0,0};
    tbl[6] = '{1,0,16'h0,1,0,16'h0,1, 1,0,16'h0,   1,1,16'hBEEF,1,0,0};
    tbl[7] = '{1,0,16'h0,0,0,16'h0,0, 1,0,16'h0,   1,0,16'h0,   0,1,0};

    reset_n = 0; cmd_v_i = 0; cmd_i = '0; cmd_ready_i = 0;
    resp_v_i = 0; resp_i = '0; resp_yumi_i = 0;
    m_out = 0; m_peak = 0; m_err = 0; m_stall = '0;
    repeat (2) @(posedge clk);
    #1;

    // Basic single transaction
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].rn, tbl[i].cv, tbl[i].cd, tbl[i].cr, tbl[i].rv, tbl[i].rd, tbl[i].y);
      check("tbl_cmd_ready", s_cmd_rdy, tbl[i].e_cr);
      check("tbl_cmd_v", s_cmd_v, tbl[i].e_cv);
      check("tbl_resp_ready", s_resp_rdy, tbl[i].e_rr);
      check("tbl_resp_v", s_resp_v, tbl[i].e_rv);
      check("tbl_outstanding", s_out, tbl[i].e_out);
      check("tbl_idle", s_idle, tbl[i].e_idle);
      check("tbl_error", s_err, tbl[i].e_err);
      if (tbl[i].e_cv) check("tbl_cmd_data", s_cmd, tbl[i].e_cmd);
      if (tbl[i].e_rv) check("tbl_resp_data", s_resp, tbl[i].e_resp);
    end

    // Credit exhaustion: 6 commands, no yumi
    do_reset();
    begin
      int base;
      base = n_issued;
      for (int i = 0; i < 6; i++) tick(1, 1, 16'h0100 + 16'(i), 1, 0, 0);
      tick(1, 0, '0, 1, 0, 0);
      tick(1, 0, '0, 1, 0, 0);
      check("exh_issued", n_issued - base, 4);
      check("exh_outstanding", s_out, 4);
      check("exh_gate_closed", s_cmd_v, 0);
      for (int i = 0; i < 4; i++) tick(1, 0, '0, 1, 1, 0);
      tick(1, 0, '0, 1, 1, 1);
      check("exh_gate_yumi_cycle", s_cmd_v, 0);
      tick(1, 0, '0, 1, 1, 0);
      check("exh_reopen", s_cmd_v, 1);
      check("exh_fifth_cmd", s_cmd, 16'h0104);
      check("exh_issued5", n_issued - base, 5);
      for (int i = 0; i < 20; i++) tick(1, 0, '0, 1, 1, 1);
      check("exh_idle", s_idle, 1);
    end

    // Read followed by writeback while the CCE stalls responses
    do_reset();
    tick(1, 1, 16'hA001, 1, 0, 0);
    tick(1, 1, 16'hB002, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, '0, 1, 1, 0);
    check("dl_outstanding", s_out, 2);
    tick(1, 0, '0, 1, 1, 1);
    check("dl_first", s_resp, 16'hA001 ^ RK);
    tick(1, 0, '0, 1, 1, 1);
    check("dl_second", s_resp, 16'hB002 ^ RK);
    tick(1, 0, '0, 1, 1, 0);
    check("dl_error", s_err, 0);
    check("dl_idle", s_idle, 1);

    // Simultaneous issue and yumi at outstanding 2
    do_reset();
    tick(1, 1, 16'hC000, 1, 0, 0);
    tick(1, 1, 16'hC001, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, '0, 1, 1, 0);
    tick(1, 1, 16'hC002, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 16'hD000 + 16'(i), 1, 1, 1);
      check("stream_outstanding", s_out, 2);
    end

    // Unsolicited response
    do_reset();
    cycle(1, 0, '0, 0, 1, 16'hDEAD, 0);
    tick(1, 0, '0, 0, 0, 0);
    check("unsol_set", s_err, 1);
    tick(1, 0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, '0, 0, 0, 0);
    check("unsol_sticky", s_err, 1);
    check("unsol_outstanding", s_out, 0);
    tick(0, 0, '0, 0, 0, 0);
    tick(1, 0, '0, 0, 0, 0);
    check("unsol_cleared", s_err, 0);

    // Reset with commands buffered and credits exhausted
    do_reset();
    for (int i = 0; i < 7; i++) tick(1, 1, 16'hE000 + 16'(i), 1, 0, 0);
    tick(1, 0, '0, 1, 0, 0);
    tick(1, 0, '0, 1, 0, 0);
`ifdef BP_ME_MEM_BUFFER_STATS_EN
    check("mid_peak_before", s_peak, 4);
`endif
    tick(0, 0, '0, 1, 1, 0);
    tick(1, 0, '0, 1, 0, 0);
    check("mid_cmd_v", s_cmd_v, 0);
    check("mid_resp_v", s_resp_v, 0);
    check("mid_stall", s_stall, 0);
    check("mid_peak", s_peak, 0);
    check("mid_idle", s_idle, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 7), 16'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
